// File: rtl/line_fill_buffer_if.sv
// Bus bundle for the line fill buffer: miss request, memory burst port and
// the assembled-line / critical-word outputs. The slave modport is the buffer.
interface line_fill_buffer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int WORD_COUNT = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic                             req_valid;
  logic                             req_ready;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ADDR_WIDTH-1:0]            mem_req_addr;
  logic                             mem_rdata_valid;
  logic [WORD_WIDTH-1:0]            mem_rdata;
  logic                             line_valid;
  logic [ADDR_WIDTH-1:0]            line_addr;
  logic [WORD_WIDTH*WORD_COUNT-1:0] line_data;
  logic [SEL_WIDTH-1:0]             line_offset;
  logic                             crit_valid;
  logic [WORD_WIDTH-1:0]            crit_data;
  logic                             busy;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_req_addr, line_valid, line_addr,
           line_data, line_offset, crit_valid, crit_data, busy
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_req_addr, line_valid, line_addr,
           line_data, line_offset, crit_valid, crit_data, busy
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Line fill buffer: takes one cache-miss request, issues a single burst read,
// gathers WORD_COUNT beats into a line register and presents line, aligned
// address and byte offset with a one-cycle line_valid pulse.
// Optional feature macro: LFB_CRITICAL_WORD_FIRST_EN (burst starts at the
// missing word, wraps around the line, and pulses crit_valid/crit_data).

// One word slot of the line register; cleared by reset.
module lfb_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Capture the beat addressed to this slot.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module line_fill_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int WORD_COUNT = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  line_fill_buffer_if.slave  bus
);
  localparam int BOFF  = $clog2(WORD_WIDTH/8);
  localparam int IDX_W = $clog2(WORD_COUNT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_COUNT-1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [SEL_WIDTH-1:0]  off;
  } line_tag_t;

  state_t                               state;
  line_tag_t                            tag;
  logic                                 rdy, mreq_v, lvalid, busy_r;
  logic [ADDR_WIDTH-1:0]                mreq_a;
  logic [IDX_W-1:0]                     idx, cnt, start_idx;
  logic [ADDR_WIDTH-1:0]                aligned, first_addr;
  logic                                 beat;
  logic [WORD_COUNT-1:0]                we;
  logic [WORD_COUNT-1:0][WORD_WIDTH-1:0] words;

`ifdef LFB_CRITICAL_WORD_FIRST_EN
  assign start_idx = bus.req_addr[SEL_WIDTH-1:BOFF];
`else
  assign start_idx = '0;
`endif

  assign aligned    = {bus.req_addr[ADDR_WIDTH-1:SEL_WIDTH], {SEL_WIDTH{1'b0}}};
  assign first_addr = aligned | (ADDR_WIDTH'(start_idx) << BOFF);
  // Beats only count while filling; anything on the read bus elsewhere is dropped.
  assign beat       = (state == FILL) && bus.mem_rdata_valid;

  // Per-word slots, written when the wrap index points at them.
  for (genvar i = 0; i < WORD_COUNT; i++) begin : g_word
    assign we[i] = beat && (idx == IDX_W'(i));
    lfb_word #(.W(WORD_WIDTH)) u_word (
      .clk (clk),
      .rst_n (rst_n),
      .we  (we[i]),
      .d   (bus.mem_rdata),
      .q   (words[i])
    );
  end

  // Request/fill sequencing with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      rdy    <= 1'b1;
      mreq_v <= 1'b0;
      mreq_a <= '0;
      lvalid <= 1'b0;
      busy_r <= 1'b0;
      tag    <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          state  <= REQ;
          rdy    <= 1'b0;
          busy_r <= 1'b1;
          mreq_v <= 1'b1;
          mreq_a <= first_addr;
          tag    <= '{addr: aligned, off: bus.req_addr[SEL_WIDTH-1:0]};
          idx    <= start_idx;
          cnt    <= '0;
        end
        REQ: if (bus.mem_req_ready) begin
          mreq_v <= 1'b0;
          state  <= FILL;
        end
        FILL: if (bus.mem_rdata_valid) begin
          idx <= idx + IDX_W'(1);   // power-of-two count: natural wrap
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            lvalid <= 1'b1;
          end
        end
        DONE: begin
          lvalid <= 1'b0;
          busy_r <= 1'b0;
          rdy    <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef LFB_CRITICAL_WORD_FIRST_EN
  logic                  crit_v;
  logic [WORD_WIDTH-1:0] crit_d;

  // First beat of each fill is the missing word: forward it a cycle later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      crit_v <= 1'b0;
      crit_d <= '0;
    end else begin
      crit_v <= beat && (cnt == '0);
      if (beat && (cnt == '0)) crit_d <= bus.mem_rdata;
    end

  assign bus.crit_valid = crit_v;
  assign bus.crit_data  = crit_d;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

  assign bus.req_ready     = rdy;
  assign bus.busy          = busy_r;
  assign bus.mem_req_valid = mreq_v;
  assign bus.mem_req_addr  = mreq_a;
  assign bus.line_valid    = lvalid;
  assign bus.line_addr     = tag.addr;
  assign bus.line_offset   = tag.off;
  assign bus.line_data     = words;
endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: expected lines are pushed to a
// scoreboard at request time and popped when line_valid is seen.
module tb_line_fill_buffer;
  localparam int WW = 32;
  localparam int WC = 4;
  localparam int AW = 32;
  localparam int SW = 4;

`ifdef LFB_CRITICAL_WORD_FIRST_EN
  localparam int CWF = 1;
`else
  localparam int CWF = 0;
`endif

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WW*WC-1:0] data;
    logic [SW-1:0]    off;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_fill_buffer_if #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

  line_fill_buffer #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             sb[$];
  logic [WC-1:0][WW-1:0] model;
  int               passed = 0;
  int               total = 0;
  int               lv_cnt = 0;
  int               crit_cnt = 0;
  logic [WW-1:0]    crit_last = '0;

  // Count output pulses so unexpected line_valid / crit_valid are caught.
  always @(negedge clk) begin
    if (bus.line_valid === 1'b1) lv_cnt++;
    if (bus.crit_valid === 1'b1) begin
      crit_cnt++;
      crit_last = bus.crit_data;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 128'(bus.req_ready), 1);
    chk({tag, "_busy"}, 128'(bus.busy), 0);
    chk({tag, "_mem_req_valid"}, 128'(bus.mem_req_valid), 0);
    chk({tag, "_mem_req_addr"}, 128'(bus.mem_req_addr), 0);
    chk({tag, "_line_valid"}, 128'(bus.line_valid), 0);
    chk({tag, "_line_data"}, 128'(bus.line_data), 0);
    chk({tag, "_line_addr"}, 128'(bus.line_addr), 0);
    chk({tag, "_line_offset"}, 128'(bus.line_offset), 0);
    chk({tag, "_crit_valid"}, 128'(bus.crit_valid), 0);
    chk({tag, "_crit_data"}, 128'(bus.crit_data), 0);
  endtask

  // One full fill: stall = cycles of mem_req_ready low, gap_at = beat index
  // preceded by one idle cycle (-1 none), rogue = spurious rdata in REQ and a
  // competing req_valid during FILL.
  task automatic do_fill(input logic [AW-1:0] addr, input logic [WW-1:0] b0,
                         input int stall, input int gap_at, input bit rogue);
    exp_t          e;
    int            st, n, w, lv0, cr0;
    logic [AW-1:0] mra;
    st = (CWF != 0) ? int'(addr[SW-1:2]) : 0;
    e.addr = {addr[AW-1:SW], {SW{1'b0}}};
    mra = e.addr + AW'(st * (WW/8));
    for (int k = 0; k < WC; k++) model[(st + k) % WC] = b0 + WW'(k);
    e.data = model;
    e.off  = addr[SW-1:0];
    e.lat  = 6 + stall + ((gap_at >= 0) ? 1 : 0);
    lv0 = lv_cnt;
    cr0 = crit_cnt;

    chk("req_ready_idle", 128'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    sb.push_back(e);
    tick; n = 1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hDEAD_BEEF;
    chk("mem_req_valid", 128'(bus.mem_req_valid), 1);
    chk("mem_req_addr", 128'(bus.mem_req_addr), 128'(mra));
    chk("busy_req", 128'(bus.busy), 1);

    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      if (rogue) begin
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = 32'hBAD0_0000 + WW'(s);
      end
      tick; n++;
      chk("mem_req_valid_stall", 128'(bus.mem_req_valid), 1);
      chk("mem_req_addr_stall", 128'(bus.mem_req_addr), 128'(mra));
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick; n++;
    bus.mem_req_ready = 1'b0;
    chk("mem_req_valid_drop", 128'(bus.mem_req_valid), 0);

    for (int k = 0; k < WC; k++) begin
      if (k == gap_at) begin
        bus.mem_rdata_valid = 1'b0;
        tick; n++;
      end
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = b0 + WW'(k);
      if (rogue) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_5550;
      end
      tick; n++;
      if (rogue) chk("req_ready_busy", 128'(bus.req_ready), 0);
    end
    bus.mem_rdata_valid = 1'b0;
    bus.req_valid = 1'b0;

    w = 0;
    while (bus.line_valid !== 1'b1 && w < 30) begin
      tick; n++; w++;
    end
    if (bus.line_valid !== 1'b1) begin
      chk("line_valid_timeout", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("line_latency", 128'(n), 128'(e.lat));
      chk("line_data", 128'(bus.line_data), 128'(e.data));
      chk("line_addr", 128'(bus.line_addr), 128'(e.addr));
      chk("line_offset", 128'(bus.line_offset), 128'(e.off));
    end
    tick;
    chk("line_valid_pulse", 128'(bus.line_valid), 0);
    chk("req_ready_after", 128'(bus.req_ready), 1);
    chk("busy_after", 128'(bus.busy), 0);
    chk("line_data_hold", 128'(bus.line_data), 128'(model));
    chk("line_valid_count", 128'(lv_cnt - lv0), 1);
    chk("crit_count", 128'(crit_cnt - cr0), 128'(CWF));
    if (CWF != 0) chk("crit_data", 128'(crit_last), 128'(b0));
    else          chk("crit_data_tied", 128'(bus.crit_data), 0);
  endtask

  initial begin
    int lv0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata = '0;
    model = '0;

    // Reset and idle hold.
    tick; tick;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick; tick;
    chk_reset_outputs("idle");

    // Stray beats while idle must be ignored.
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick; tick;
    bus.mem_rdata_valid = 1'b0;
    tick;
    chk("idle_rdata_line", 128'(bus.line_data), 0);
    chk("idle_rdata_lv", 128'(lv_cnt), 0);

    // Reference fill from the worked example.
    do_fill(32'h0000_1238, 32'h0000_00A0, 0, -1, 1'b0);
    if (CWF != 0) chk("example_line", 128'(bus.line_data), 128'h000000A1_000000A0_000000A3_000000A2);
    else          chk("example_line", 128'(bus.line_data), 128'h000000A3_000000A2_000000A1_000000A0);

    // Request stall, beat gap, stray beats in REQ, competing request in FILL.
    do_fill(32'h0000_4C04, 32'h0000_00B0, 3, 2, 1'b1);

    // Top of address space, last word of the line.
    do_fill(32'hFFFF_FFFF, 32'h0000_00C0, 1, -1, 1'b0);

    // Abort after two beats.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_2004;
    tick;
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick;
    bus.mem_req_ready = 1'b0;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata = 32'h0000_00D0;
    tick;
    bus.mem_rdata = 32'h0000_00D1;
    tick;
    bus.mem_rdata_valid = 1'b0;
    lv0 = lv_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    model = '0;
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk("abort_no_line", 128'(lv_cnt - lv0), 0);

    do_fill(32'h0000_2010, 32'h0000_00E0, 0, -1, 1'b0);
    chk("scoreboard_empty", 128'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
